// File: rtl/axi4_reg_master_pkg.sv
// rtl/axi4_reg_master_pkg.sv - shared FSM state and AXI response codes
package axi4_reg_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_reg_master_timeout_ctr.sv
// rtl/axi4_reg_master_timeout_ctr.sv - saturating transaction cycle counter
module axi_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != CW'(LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Flags the edge on which the count reaches LIMIT-1; stays set while saturated.
  assign expired = enable && (count >= CW'(LIMIT - 2));

endmodule

// File: rtl/axi4_reg_master.sv
// rtl/axi4_reg_master.sv - single-outstanding AXI4-Lite register master
module axi4_reg_master
  import axi4_reg_master_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_start,
  input  logic                      rd_start,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      idle,
  output logic                      done,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                resp,
  output logic                      timeout,
  output logic [AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
  output logic                      AXI_AWVALID,
  input  logic                      AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0] AXI_WDATA,
  output logic                      AXI_WVALID,
  input  logic                      AXI_WREADY,
  input  logic [1:0]                AXI_BRESP,
  input  logic                      AXI_BVALID,
  output logic                      AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  output logic                      AXI_ARVALID,
  input  logic                      AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0] AXI_RDATA,
  input  logic                      AXI_RVALID,
  input  logic [1:0]                AXI_RRESP,
  output logic                      AXI_RREADY
);

  state_t state;
  logic   ctr_clear, ctr_enable, expired, advance, abort;

  assign ctr_clear  = (state == IDLE) && (wr_start || rd_start);
  assign ctr_enable = (state != IDLE);

  axi_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (expired)
  );

  // A state's exit handshake beats a timeout landing on the same edge.
  always_comb begin
    advance = 1'b0;
    case (state)
      WR_ADDR_DATA: advance = (!AXI_AWVALID || AXI_AWREADY) && (!AXI_WVALID || AXI_WREADY);
      WR_RESP:      advance = AXI_BVALID;
      RD_ADDR:      advance = AXI_ARREADY;
      RD_DATA:      advance = AXI_RVALID;
      default:      advance = 1'b0;
    endcase
  end

  assign abort = expired && (state != IDLE) && !advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idle        <= 1'b1;
      done        <= 1'b0;
      timeout     <= 1'b0;
      rdata       <= '0;
      resp        <= OKAY;
      AXI_AWADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WDATA   <= '0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARADDR  <= '0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start) begin
            AXI_AWADDR  <= addr;
            AXI_WDATA   <= wdata;
            AXI_AWVALID <= 1'b1;
            AXI_WVALID  <= 1'b1;
            idle        <= 1'b0;
            state       <= WR_ADDR_DATA;
          end else if (rd_start) begin
            AXI_ARADDR  <= addr;
            AXI_ARVALID <= 1'b1;
            idle        <= 1'b0;
            state       <= RD_ADDR;
          end
        end
        WR_ADDR_DATA: begin
          if (AXI_AWREADY) AXI_AWVALID <= 1'b0;
          if (AXI_WREADY)  AXI_WVALID  <= 1'b0;
          if (advance) begin
            AXI_BREADY <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (advance) begin
            resp       <= AXI_BRESP;
            timeout    <= 1'b0;
            done       <= 1'b1;
            AXI_BREADY <= 1'b0;
            idle       <= 1'b1;
            state      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (advance) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (advance) begin
            rdata      <= AXI_RDATA;
            resp       <= AXI_RRESP;
            timeout    <= 1'b0;
            done       <= 1'b1;
            AXI_RREADY <= 1'b0;
            idle       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          idle  <= 1'b1;
          state <= IDLE;
        end
      endcase
      if (abort) begin
        AXI_AWVALID <= 1'b0;
        AXI_WVALID  <= 1'b0;
        AXI_BREADY  <= 1'b0;
        AXI_ARVALID <= 1'b0;
        AXI_RREADY  <= 1'b0;
        resp        <= SLVERR;
        timeout     <= 1'b1;
        done        <= 1'b1;
        idle        <= 1'b1;
        state       <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axi4_reg_master.sv
// tb/tb_axi4_reg_master.sv - directed bench for axi4_reg_master
module tb_axi4_reg_master;

  logic        clk = 1'b0;
  logic        reset, wr_start, rd_start;
  logic [31:0] addr, wdata;
  logic        idle, done, timeout;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0;
  int b_hs = 0;
  int ar_hs = 0;

  always #5 clk = ~clk;

  axi4_reg_master #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .wr_start(wr_start), .rd_start(rd_start),
    .addr(addr), .wdata(wdata), .idle(idle), .done(done), .rdata(rdata),
    .resp(resp), .timeout(timeout),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RVALID(AXI_RVALID), .AXI_RRESP(AXI_RRESP),
    .AXI_RREADY(AXI_RREADY)
  );

  always @(posedge clk) begin
    if (!reset && AXI_AWVALID && AXI_AWREADY) aw_hs++;
    if (!reset && AXI_BVALID && AXI_BREADY) b_hs++;
    if (!reset && AXI_ARVALID && AXI_ARREADY) ar_hs++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic slave(input logic awr, wr, bv, arr, rv);
    AXI_AWREADY = awr; AXI_WREADY = wr; AXI_BVALID = bv;
    AXI_ARREADY = arr; AXI_RVALID = rv;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_start = 1'b0; rd_start = 1'b0; addr = '0; wdata = '0;
    slave(0, 0, 0, 0, 0); AXI_BRESP = 2'b00; AXI_RRESP = 2'b00; AXI_RDATA = '0;
    tick(); tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    checks++; if ({done, timeout} !== 2'b00) begin errors++; $display("FAIL reset_done_timeout got %b exp 00", {done, timeout}); end
    checks++; if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 00000", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}); end
    checks++; if ({rdata, resp} !== 34'h0) begin errors++; $display("FAIL reset_rdata_resp got %h/%b exp 0/00", rdata, resp); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_fast();
    slave(1, 1, 1, 0, 0); AXI_BRESP = 2'b00;
    wr_start = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    tick(); wr_start = 1'b0; addr = '0; wdata = '0;
    checks++; if ({AXI_AWVALID, AXI_WVALID, idle} !== 3'b110) begin errors++; $display("FAIL wf_valids got %b exp 110", {AXI_AWVALID, AXI_WVALID, idle}); end
    checks++; if (AXI_AWADDR !== 32'h10 || AXI_WDATA !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wf_payload got %h/%h exp 00000010/deadbeef", AXI_AWADDR, AXI_WDATA); end
    tick();
    checks++; if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, done} !== 4'b0010) begin
      errors++; $display("FAIL wf_resp_phase got %b exp 0010", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, done}); end
    tick();
    checks++; if ({done, timeout, resp, idle, AXI_BREADY} !== 6'b100010) begin
      errors++; $display("FAIL wf_done_n3 got %b exp 100010", {done, timeout, resp, idle, AXI_BREADY}); end
    slave(0, 0, 0, 0, 0);
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wf_done_one_cycle got %b exp 0", done); end
  endtask

  task automatic test_read_delay();
    slave(0, 0, 0, 0, 1); AXI_RDATA = 32'h12345678; AXI_RRESP = 2'b11;
    rd_start = 1'b1; addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick(); rd_start = 1'b0; addr = 32'hFFFF_FFFF;
      if (i == 3) AXI_ARREADY = 1'b1;
      checks++; if (AXI_ARVALID !== 1'b1 || AXI_ARADDR !== 32'h20) begin
        errors++; $display("FAIL rd_araddr_stable cycle %0d got %b/%h exp 1/00000020", i, AXI_ARVALID, AXI_ARADDR); end
    end
    tick(); AXI_ARREADY = 1'b0;
    checks++; if ({AXI_ARVALID, AXI_RREADY, done} !== 3'b010) begin errors++; $display("FAIL rd_data_phase got %b exp 010", {AXI_ARVALID, AXI_RREADY, done}); end
    tick(); AXI_RVALID = 1'b0;
    checks++; if ({done, timeout, resp} !== 4'b1011 || rdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_result got %b/%h exp 1011/12345678", {done, timeout, resp}, rdata); end
    tick();
  endtask

  task automatic test_write_split();
    int b0;
    b0 = b_hs;
    slave(1, 0, 1, 0, 0); AXI_BRESP = 2'b01;
    wr_start = 1'b1; addr = 32'h44; wdata = 32'hA5A50001;
    tick(); wr_start = 1'b0;
    checks++; if ({AXI_AWVALID, AXI_WVALID} !== 2'b11) begin errors++; $display("FAIL ws_start got %b exp 11", {AXI_AWVALID, AXI_WVALID}); end
    tick(); AXI_AWREADY = 1'b0;
    checks++; if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY} !== 3'b010) begin errors++; $display("FAIL ws_aw_first got %b exp 010", {AXI_AWVALID, AXI_WVALID, AXI_BREADY}); end
    tick(); AXI_WREADY = 1'b1;
    checks++; if (AXI_WVALID !== 1'b1 || AXI_WDATA !== 32'hA5A50001) begin errors++; $display("FAIL ws_w_hold got %b/%h exp 1/a5a50001", AXI_WVALID, AXI_WDATA); end
    tick(); AXI_WREADY = 1'b0;
    checks++; if ({AXI_WVALID, AXI_BREADY} !== 2'b01) begin errors++; $display("FAIL ws_bresp_phase got %b exp 01", {AXI_WVALID, AXI_BREADY}); end
    tick();
    checks++; if ({done, resp} !== 3'b101) begin errors++; $display("FAIL ws_done got %b exp 101", {done, resp}); end
    tick(); tick(); AXI_BVALID = 1'b0;
    checks++; if (b_hs - b0 !== 1) begin errors++; $display("FAIL ws_b_count got %0d exp 1", b_hs - b0); end
  endtask

  task automatic test_timeout();
    slave(0, 0, 0, 0, 0);
    wr_start = 1'b1; addr = 32'h50; wdata = 32'h5;
    for (int k = 1; k <= 7; k++) begin
      tick(); wr_start = 1'b0;
      checks++; if ({done, idle} !== 2'b00) begin errors++; $display("FAIL to_wait cycle %0d got %b exp 00", k, {done, idle}); end
    end
    tick();
    checks++; if ({done, timeout, resp, idle} !== 5'b11101) begin errors++; $display("FAIL to_abort got %b exp 11101", {done, timeout, resp, idle}); end
    checks++; if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 5'b0) begin
      errors++; $display("FAIL to_handshake_low got %b exp 00000", {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL to_rdata_kept got %h exp 12345678", rdata); end
    tick();
  endtask

  task automatic test_conflict();
    int ar0, aw0;
    ar0 = ar_hs; aw0 = aw_hs;
    slave(1, 1, 1, 1, 1); AXI_BRESP = 2'b00;
    wr_start = 1'b1; rd_start = 1'b1; addr = 32'h80; wdata = 32'h11223344;
    tick(); wr_start = 1'b0;
    checks++; if ({AXI_AWVALID, AXI_ARVALID} !== 2'b10) begin errors++; $display("FAIL cf_write_wins got %b exp 10", {AXI_AWVALID, AXI_ARVALID}); end
    tick(); rd_start = 1'b0;
    checks++; if (AXI_ARVALID !== 1'b0) begin errors++; $display("FAIL cf_busy_read got %b exp 0", AXI_ARVALID); end
    tick();
    checks++; if ({done, timeout, resp} !== 4'b1000 || rdata !== 32'h12345678) begin
      errors++; $display("FAIL cf_done got %b/%h exp 1000/12345678", {done, timeout, resp}, rdata); end
    tick(); slave(0, 0, 0, 0, 0);
    checks++; if (ar_hs - ar0 !== 0 || aw_hs - aw0 !== 1 || idle !== 1'b1) begin
      errors++; $display("FAIL cf_counts got ar %0d aw %0d idle %b exp 0 1 1", ar_hs - ar0, aw_hs - aw0, idle); end
  endtask

  task automatic test_reset_mid();
    slave(1, 1, 0, 0, 0);
    wr_start = 1'b1; addr = 32'h60; wdata = 32'h6;
    tick(); wr_start = 1'b0;
    tick();
    checks++; if (AXI_BREADY !== 1'b1) begin errors++; $display("FAIL rm_in_wr_resp got %b exp 1", AXI_BREADY); end
    reset = 1'b1;
    tick(); reset = 1'b0; AXI_BVALID = 1'b1;
    checks++; if ({idle, done, timeout, AXI_BREADY, AXI_AWVALID, AXI_WVALID} !== 6'b100000 || rdata !== 32'h0 || resp !== 2'b00) begin
      errors++; $display("FAIL rm_outputs got %b/%h/%b exp 100000/0/00", {idle, done, timeout, AXI_BREADY, AXI_AWVALID, AXI_WVALID}, rdata, resp); end
    tick(); slave(0, 0, 0, 1, 1); AXI_RDATA = 32'hCAFEF00D; AXI_RRESP = 2'b00;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_no_done got %b exp 0", done); end
    rd_start = 1'b1; addr = 32'h30;
    tick(); rd_start = 1'b0;
    checks++; if (AXI_ARVALID !== 1'b1 || AXI_ARADDR !== 32'h30) begin errors++; $display("FAIL rm_read_ar got %b/%h exp 1/00000030", AXI_ARVALID, AXI_ARADDR); end
    tick(); tick();
    checks++; if ({done, timeout, resp} !== 4'b1000 || rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rm_read_done got %b/%h exp 1000/cafef00d", {done, timeout, resp}, rdata); end
    slave(0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_write_fast();
    test_read_delay();
    test_write_split();
    test_timeout();
    test_conflict();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
